// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle CPU control sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT)
// Strobes are registered from the next state and opcode, so they always reflect state and op_q.
module multicycle_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       opcode,
   input  logic             mem_ready,
   input  logic             halt_req,
   output logic             ir_we,
   output logic             pc_en,
   output logic             brnch,
   output logic             mem_sc,
   output logic             memWE,
   output logic             regWE,
   output logic             lw,
   output logic             accWE,
   output logic             acc_sc,
   output logic [1:0]       cntr_alu,
   output logic [2:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   typedef struct packed {
      logic       ir_we;
      logic       mem_sc;
      logic       mem_we;
      logic       reg_we;
      logic       lw;
      logic       acc_we;
      logic       acc_sc;
      logic [1:0] cntr_alu;
      logic       halted;
   } ctl_t;

   state_t           state_q;
   state_t           state_n;
   logic [2:0]       op_q;
   logic [2:0]       op_n;
   logic             retire;
   logic [CNT_W-1:0] count_q;
   ctl_t             ctl_q;

   function automatic ctl_t decode(input state_t s, input logic [2:0] op);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: c.ir_we = 1'b1;
         S_EXEC: begin
            if (!op[2]) begin
               c.cntr_alu = op[1:0];
            end else if (op == 3'b100) begin
               c.acc_we = 1'b1;
            end else if (op == 3'b101) begin
               c.acc_we = 1'b1;
               c.acc_sc = 1'b1;
            end
         end
         S_MEM: begin
            c.mem_sc = 1'b1;
            c.mem_we = (op == 3'b111);
         end
         S_WB: begin
            c.reg_we = 1'b1;
            c.lw     = (op == 3'b110);
            if (!op[2]) c.cntr_alu = op[1:0];
         end
         S_HALT: c.halted = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_n = state_q;
      op_n    = op_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE:   if (start) state_n = S_FETCH;
         S_FETCH:  if (mem_ready) state_n = S_DECODE;
         S_DECODE: begin
            op_n    = opcode;
            state_n = (opcode[2:1] == 2'b11) ? S_MEM : S_EXEC;
         end
         S_EXEC: begin
            if (!op_q[2]) state_n = S_WB;
            else          retire  = 1'b1;
         end
         S_MEM: begin
            if (mem_ready) begin
               if (op_q == 3'b110) state_n = S_WB;
               else                retire  = 1'b1;
            end
         end
         S_WB:   retire = 1'b1;
         S_HALT: state_n = S_HALT;
         default: state_n = S_IDLE;
      endcase
      // halt_req only matters on the retire edge; mid-instruction requests are dropped
      if (retire) state_n = halt_req ? S_HALT : S_FETCH;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= 3'b000;
         count_q <= '0;
         ctl_q   <= '0;
      end else begin
         state_q <= state_n;
         op_q    <= op_n;
         if (retire) count_q <= count_q + CNT_W'(1);
         ctl_q   <= decode(state_n, op_n);
      end
   end

   // PC advances only on the FETCH cycle where memory actually returns the instruction
   assign pc_en       = ctl_q.ir_we & mem_ready;
   assign ir_we       = ctl_q.ir_we;
   assign brnch       = 1'b0;
   assign mem_sc      = ctl_q.mem_sc;
   assign memWE       = ctl_q.mem_we;
   assign regWE       = ctl_q.reg_we;
   assign lw          = ctl_q.lw;
   assign accWE       = ctl_q.acc_we;
   assign acc_sc      = ctl_q.acc_sc;
   assign cntr_alu    = ctl_q.cntr_alu;
   assign halted      = ctl_q.halted;
   assign state       = state_q;
   assign instr_count = count_q;

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; no other clock or reset.
REQ-002 SHALL have parameter CNT_W, default 16, the width of instr_count.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-005 SHALL have port start, input, 1: leave IDLE and begin fetching.
REQ-006 SHALL have port opcode, input, 3: instruction-register opcode field, valid in DECODE.
REQ-007 SHALL have port mem_ready, input, 1: memory access completes this cycle.
REQ-008 SHALL have port halt_req, input, 1: stop after the current instruction.
REQ-009 SHALL have port ir_we, output, 1: load the instruction register from memory output.
REQ-010 SHALL have port pc_en, output, 1: PC increment.
REQ-011 SHALL have port brnch, output, 1: PC load from ALU.
REQ-012 SHALL have port mem_sc, output, 1: memory address select (0 = PC, 1 = accumulator).
REQ-013 SHALL have port memWE, output, 1: memory write enable.
REQ-014 SHALL have port regWE, output, 1: register-file write enable.
REQ-015 SHALL have port lw, output, 1: register write-data select (0 = ALU, 1 = memory).
REQ-016 SHALL have port accWE, output, 1: accumulator write enable.
REQ-017 SHALL have port acc_sc, output, 1: accumulator input select (0 = register, 1 = sign-extended immediate).
REQ-018 SHALL have port cntr_alu, output, 2: ALU operation.
REQ-019 SHALL have port state, output, 3: current state encoding.
REQ-020 SHALL have port halted, output, 1: sequencer is in HALT.
REQ-021 SHALL have port instr_count, output, CNT_W: count of retired instructions.

Function
REQ-022 SHALL use states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; value 7 SHALL go to IDLE.
REQ-023 SHALL generate all outputs as Moore functions of state and op_q; every output not listed for a state SHALL be 0.
REQ-024 SHALL latch opcode into op_q on the clock edge that leaves DECODE.
REQ-025 IDLE: next state SHALL be FETCH if start=1, else IDLE.
REQ-026 FETCH: mem_sc=0 and ir_we=1; if mem_ready=1, pc_en=1 and next state SHALL be DECODE; if mem_ready=0, the state SHALL hold with pc_en=0.
REQ-027 DECODE: no strobes; next state SHALL be MEM for opcode 110 or 111, else EXEC.
REQ-028 EXEC, ALU class (op_q 000-011): cntr_alu=op_q[1:0]; next state SHALL be WB.
REQ-029 EXEC, 100 LDA: accWE=1, acc_sc=0; the instruction SHALL retire.
REQ-030 EXEC, 101 LDI: accWE=1, acc_sc=1; the instruction SHALL retire.
REQ-031 EXEC, other: op_q 111 never reaches EXEC; reserved encodings SHALL retire with no strobes.
REQ-032 MEM: mem_sc=1; for 111 SW, memWE=1 every cycle while in MEM. MEM SHALL hold while mem_ready=0. On mem_ready=1, 110 LW SHALL go to WB and 111 SW SHALL retire.
REQ-033 WB: regWE=1 and lw=(op_q==110); cntr_alu=op_q[1:0] for the ALU class; the instruction SHALL retire.
REQ-034 Latency from FETCH entry to retire with mem_ready=1: ALU 4 cycles; LDA, LDI and SW 3 cycles; LW 4 cycles.
REQ-035 Branch: brnch SHALL be asserted in EXEC when op_q==011 and opcode field of next use is BR; the branch variant is disabled and brnch SHALL remain 0 in this revision.
REQ-036 Retire: instr_count SHALL increment by 1 and wrap modulo 2^CNT_W; next state SHALL be HALT if halt_req=1, else FETCH.
REQ-037 halt_req outside a retire cycle SHALL be ignored; an in-flight instruction always completes.
REQ-038 HALT: halted=1, all strobes 0; HALT SHALL be left only by reset, and start SHALL be ignored.
REQ-039 regWE, memWE and accWE SHALL never be asserted in the same cycle.

Reset
REQ-040 With reset=1 at a rising edge: state SHALL become IDLE, op_q=000, instr_count=0.
REQ-041 During and after reset, all strobes and halted SHALL be 0 and cntr_alu=00.
REQ-042 Reset SHALL take priority over start, mem_ready, halt_req and any mid-instruction state, aborting the instruction with no further strobes.

Verification
REQ-043 Reset, start=1, opcode=000, mem_ready=1: state SHALL run 1,2,3,5,1; regWE=1 only in WB; cntr_alu=00; instr_count=1.
REQ-044 opcode=110 with mem_ready=0 for 3 MEM cycles, then 1: mem_sc=1 for 4 cycles, then WB with lw=1 and regWE=1.
REQ-045 opcode=111 with mem_ready=1: memWE=1 for exactly 1 cycle; no WB; state returns to FETCH; count increments.
REQ-046 halt_req=1 raised during DECODE of LDI: EXEC with accWE=1 and acc_sc=1 SHALL occur, then HALT with halted=1; start pulse SHALL have no effect.
REQ-047 Reset asserted in MEM of SW: memWE SHALL be 0 from the next cycle; state=IDLE; instr_count=0.
REQ-048 CNT_W=4, 16 LDA instructions: instr_count SHALL wrap to 0.
